// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: control states and PC/instruction constants.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_fsm.sv
// Fetch control sequencing: state register and next-state logic only.
module pc_fetch_fsm
  import pc_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       redirect_i,
  input  logic       ack_i,
  input  logic       ready_i,
  output logic [1:0] state_o
);

  state_e state_q, state_d;

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (ack_i)           state_d = redirect_i ? FETCH : HOLD;
        else if (redirect_i) state_d = DRAIN;
      end
      HOLD:  if (redirect_i || ready_i) state_d = FETCH;
      DRAIN: if (ack_i) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: owns the PC, issues imem reads over req/ack and hands one
// instruction at a time to decode over valid/ready. Redirects override everything.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = pc_fetch_pkg::INST_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        stop,
  input  logic [31:0] pcnext,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        imem_req_q, imem_req_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] target;
  logic [31:0] fetch_addr;
  logic        live_ack;

  pc_fetch_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .redirect_i (redirect),
    .ack_i      (imem_ack),
    .ready_i    (inst_ready),
    .state_o    (state)
  );

  assign target     = redirect_pc & pc_fetch_pkg::PC_ALIGN_MASK;
  // Any new request goes to the redirect target if one arrives this cycle.
  assign fetch_addr = redirect ? target : pc_q;
  assign live_ack   = (state == pc_fetch_pkg::FETCH) && imem_ack && !redirect;

  always_comb begin
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    case (state)
      pc_fetch_pkg::IDLE: begin
        imem_req_d  = 1'b1;
        imem_addr_d = fetch_addr;
      end
      pc_fetch_pkg::FETCH: begin
        if (live_ack) begin
          inst_d       = imem_rdata;
          inst_pc_d    = imem_addr_q;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
        end else if (imem_ack) begin
          imem_addr_d = fetch_addr;
        end
      end
      pc_fetch_pkg::HOLD: begin
        if (redirect || inst_ready) begin
          inst_valid_d = 1'b0;
          imem_req_d   = 1'b1;
          imem_addr_d  = fetch_addr;
        end
      end
      pc_fetch_pkg::DRAIN: begin
        if (imem_ack) imem_addr_d = fetch_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      inst_valid_q <= 1'b0;
      inst_q       <= INST_NOP;
      inst_pc_q    <= 32'h0;
    end else begin
      pc_q         <= redirect ? target : pcnext;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign pc         = pc_q;
  assign stop       = !live_ack;
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_valid_q ? inst_q : INST_NOP;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: a memory responder and stimulus driver feed a
// program-order reference model whose expectations a separate monitor checks.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk, rst_n;
  logic [31:0] pc, pcnext, redirect_pc, imem_addr, imem_rdata, inst, inst_pc;
  logic        stop, redirect, imem_req, imem_ack, inst_valid, inst_ready;

  pc_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .stop        (stop),
    .pcnext      (pcnext),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  // External PC-increment adder.
  assign pcnext = stop ? pc : pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } inst_exp_t;
  typedef struct { logic [31:0] pc; logic stop; logic addr_chk; logic [31:0] addr; } cyc_exp_t;

  inst_exp_t   inst_q[$];
  cyc_exp_t    cyc_q[$];
  inst_exp_t   pend;
  cyc_exp_t    mon_c;
  int          checks, errors, accepted, idle_run, lat_cnt, force_lat;
  logic [31:0] mdl_pc, req_addr_exp, redir_tgt;
  logic        pend_vld, stale, prev_req, prev_ack, mon_en, redir_on_start, redir_on_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_stop", {31'b0, stop}, 32'd1);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_inst_pc", inst_pc, 32'h0);
    inst_q.delete();
    cyc_q.delete();
    pend_vld = 1'b0; stale = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    lat_cnt = 0; force_lat = -1; idle_run = 0;
    redir_on_start = 1'b0; redir_on_valid = 1'b0;
    mdl_pc = RESET_PC;
    // A stale acknowledge arrives in the first cycle after release.
    redirect = 1'b0; inst_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic do_cycle(input int lat_max, input int ready_pct, input int redir_pct, input int spur_pct);
    logic [31:0] tgt;
    logic        req_start, live_ack, forced;
    cyc_exp_t    c;
    @(posedge clk);
    #1;
    if (pend_vld) begin
      inst_q.push_back(pend);
      pend_vld = 1'b0;
    end
    req_start = imem_req && (!prev_req || prev_ack);
    if (req_start) begin
      stale        = 1'b0;
      req_addr_exp = mdl_pc;
      lat_cnt      = (force_lat >= 0) ? force_lat : $urandom_range(lat_max, 0);
      force_lat    = -1;
    end
    forced = (redir_on_start && req_start) || (redir_on_valid && inst_valid);
    inst_ready = ($urandom_range(99, 0) < ready_pct);
    if (forced) begin
      tgt = redir_tgt;
      if (redir_on_valid) inst_ready = 1'b1;
      redir_on_start = 1'b0;
      redir_on_valid = 1'b0;
    end else if ($urandom_range(3, 0) == 0) begin
      tgt = 32'hFFFF_FFF0 | $urandom_range(15, 0);
    end else begin
      tgt = $urandom;
    end
    redirect    = forced || ($urandom_range(99, 0) < redir_pct);
    redirect_pc = tgt;
    if (imem_req) begin
      imem_ack = (lat_cnt == 0);
      if (lat_cnt > 0) lat_cnt--;
    end else begin
      imem_ack = ($urandom_range(99, 0) < spur_pct);
    end
    imem_rdata = imem_req ? mem_word(imem_addr) : $urandom;
    live_ack   = imem_ack && imem_req && !stale && !redirect;
    c.pc = mdl_pc; c.stop = !live_ack; c.addr_chk = imem_req; c.addr = req_addr_exp;
    cyc_q.push_back(c);
    if (redirect) begin
      if (imem_req && !imem_ack) stale = 1'b1;
      mdl_pc = tgt & 32'hFFFF_FFFC;
    end else if (live_ack) begin
      pend     = '{pc: mdl_pc, inst: mem_word(mdl_pc)};
      pend_vld = 1'b1;
      mdl_pc   = mdl_pc + 32'd4;
    end
    prev_req = imem_req;
    prev_ack = imem_ack;
    idle_run = (!imem_req && !inst_valid) ? idle_run + 1 : 0;
    if (idle_run > 4) begin
      checks++;
      errors++;
      $display("FAIL stall actual=%0d idle cycles expected<=4 t=%0t", idle_run, $time);
      idle_run = 0;
    end
  endtask

  // Monitor: compares outputs against the queued expectations each cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (cyc_q.size() > 0) begin
        mon_c = cyc_q.pop_front();
        check("pc", pc, mon_c.pc);
        check("stop", {31'b0, stop}, {31'b0, mon_c.stop});
        if (mon_c.addr_chk) check("imem_addr", imem_addr, mon_c.addr);
      end
      check("req_with_valid", {31'b0, imem_req & inst_valid}, 32'd0);
      if (inst_valid) begin
        if (inst_q.size() == 0) begin
          check("spurious_valid", {31'b0, inst_valid}, 32'd0);
        end else begin
          check("inst_pc", inst_pc, inst_q[0].pc);
          check("inst", inst, inst_q[0].inst);
          if (redirect || inst_ready) begin
            void'(inst_q.pop_front());
            if (!redirect) accepted++;
          end
        end
      end else begin
        check("inst_nop", inst, NOP);
        if (inst_q.size() != 0) check("missing_valid", {31'b0, inst_valid}, 32'd1);
      end
    end
  end

  initial begin
    int acc0;
    checks = 0; errors = 0; accepted = 0;
    rst_n = 1'b1; mon_en = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    redir_tgt = 32'h0;
    do_reset();

    // Zero-wait stream with decode always ready: one instruction per two cycles.
    acc0 = accepted;
    repeat (20) do_cycle(0, 100, 0, 0);
    @(negedge clk); #1;
    check("stream_rate", accepted - acc0, 32'd10);

    // Backpressure with slow memory.
    repeat (40) do_cycle(2, 15, 0, 0);

    // Redirect at request start, ack delayed three cycles: drain then refetch 0x100.
    force_lat = 3; redir_tgt = 32'h0000_0103; redir_on_start = 1'b1;
    repeat (16) do_cycle(0, 100, 0, 0);

    // Redirect coincident with a zero-wait ack.
    force_lat = 0; redir_tgt = 32'h0000_0200; redir_on_start = 1'b1;
    repeat (10) do_cycle(0, 100, 0, 0);

    // Redirect while holding with decode ready: the held instruction is dropped.
    redir_tgt = 32'h0000_0300; redir_on_valid = 1'b1;
    repeat (10) do_cycle(0, 100, 0, 0);

    // Wrap from the top of the address space to zero.
    force_lat = 0; redir_tgt = 32'hFFFF_FFFF; redir_on_start = 1'b1;
    repeat (12) do_cycle(0, 100, 0, 0);

    // Fully random traffic, reset in the middle of a request, more random traffic.
    repeat (1500) do_cycle(3, 60, 8, 5);
    for (int i = 0; i < 20 && !imem_req; i++) do_cycle(3, 60, 0, 0);
    do_reset();
    repeat (500) do_cycle(3, 60, 8, 5);

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
